// File: rtl/freqdiv_pkg.sv
// Shared constants, command payload and tap-mask helper for the freqdiv_sched divider controller.
package freqdiv_pkg;

  localparam int unsigned CNT_W_DEF = 27;
  localparam int unsigned N_CH_DEF  = 4;
  localparam int unsigned SEL_W_DEF = 2;
  localparam int unsigned ST_W      = 2;
  localparam int unsigned TC_W      = 8;

  localparam logic [ST_W-1:0] IDLE  = 2'd0;
  localparam logic [ST_W-1:0] RUN   = 2'd1;
  localparam logic [ST_W-1:0] PAUSE = 2'd2;
  localparam logic [ST_W-1:0] STEP  = 2'd3;

  typedef struct packed {
    logic start;
    logic pause;
    logic stop;
    logic step;
  } cmd_t;

  // All-ones mask covering the low (cnt_w - k) counter bits for tap k.
  function automatic logic [31:0] tap_mask(input int unsigned cnt_w, input int unsigned k);
    return (32'd1 << (cnt_w - k)) - 32'd1;
  endfunction

endpackage

// File: rtl/freqdiv_sched_if.sv
// Command/enable/rate inputs and tick/clock/status outputs of freqdiv_sched.
// FREQDIV_SCHED_TICKCNT_EN adds the per-channel tick_cnt bus.
interface freqdiv_sched_if
  import freqdiv_pkg::*;
#(
  parameter int unsigned N_CH  = N_CH_DEF,
  parameter int unsigned SEL_W = SEL_W_DEF
);

  cmd_t                    cmd;
  logic [N_CH-1:0]         ch_en;
  logic [N_CH*SEL_W-1:0]   rate_sel;
  logic [N_CH-1:0]         tick;
  logic                    clk_out;
  logic [ST_W-1:0]         state_o;
`ifdef FREQDIV_SCHED_TICKCNT_EN
  logic [N_CH*TC_W-1:0]    tick_cnt;

  modport master (output cmd, ch_en, rate_sel, input tick, clk_out, state_o, tick_cnt);
  modport slave  (input cmd, ch_en, rate_sel, output tick, clk_out, state_o, tick_cnt);
`else
  modport master (output cmd, ch_en, rate_sel, input tick, clk_out, state_o);
  modport slave  (input cmd, ch_en, rate_sel, output tick, clk_out, state_o);
`endif

endinterface

// File: rtl/freqdiv_tick_gen.sv
// Per-channel tap compare and registered tick; optional saturating tick counter
// under FREQDIV_SCHED_TICKCNT_EN.
module freqdiv_tick_gen
  import freqdiv_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             is_run,
  input  logic             is_step,
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  input  logic [CNT_W-1:0] cnt,
  input  logic             clr,
`ifdef FREQDIV_SCHED_TICKCNT_EN
  output logic [TC_W-1:0]  tick_cnt,
`endif
  output logic             tick
);

  logic [CNT_W-1:0] mask_c;
  logic             match_c;
  logic             tick_d;

  assign mask_c  = CNT_W'(tap_mask(CNT_W, 32'(sel)));
  assign match_c = ((cnt & mask_c) == mask_c);

  // Rate select and enable are consumed live each cycle.
  always_comb begin
    tick_d = 1'b0;
    if (is_run) begin
      tick_d = en & match_c;
    end else if (is_step) begin
      tick_d = en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick <= 1'b0;
    end else begin
      tick <= tick_d;
    end
  end

`ifdef FREQDIV_SCHED_TICKCNT_EN
  // Counts emitted pulses, holding at full scale; wiped while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (clr) begin
      tick_cnt <= '0;
    end else if (tick && (tick_cnt != {TC_W{1'b1}})) begin
      tick_cnt <= tick_cnt + TC_W'(1);
    end
  end
`endif

endmodule

// File: rtl/freqdiv_sched.sv
// Divider controller: FSM and shared counter, fanned out to per-channel tick generators.
// Optional per-channel tick counters under FREQDIV_SCHED_TICKCNT_EN.
module freqdiv_sched
  import freqdiv_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned N_CH  = N_CH_DEF,
  parameter int unsigned SEL_W = SEL_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  freqdiv_sched_if.slave  bus
);

  logic [ST_W-1:0]  state_q;
  logic [ST_W-1:0]  state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             clk_out_q;
  logic             clr_c;
  logic [N_CH-1:0]  tick_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clk_out_q <= (state_d != IDLE) & cnt_d[CNT_W-1];
    end
  end

  // Next state with stop dominating; counter advances only from RUN, clears on any IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.cmd.stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.cmd.start) state_d = RUN;
        RUN:     if (bus.cmd.pause) state_d = PAUSE;
        PAUSE: begin
          if (bus.cmd.start)     state_d = RUN;
          else if (bus.cmd.step) state_d = STEP;
        end
        STEP:    state_d = PAUSE;
        default: state_d = IDLE;
      endcase
    end
    if (state_d == IDLE) begin
      cnt_d = '0;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign clr_c       = (state_q == IDLE) | (state_d == IDLE);
  assign bus.state_o = state_q;
  assign bus.clk_out = clk_out_q;
  assign bus.tick    = tick_w;

`ifdef FREQDIV_SCHED_TICKCNT_EN
  logic [N_CH*TC_W-1:0] tick_cnt_w;
  assign bus.tick_cnt = tick_cnt_w;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    freqdiv_tick_gen #(
      .CNT_W (CNT_W),
      .SEL_W (SEL_W)
    ) u_tick_gen (
      .clk      (clk),
      .rst      (rst),
      .is_run   (state_q == RUN),
      .is_step  (state_q == STEP),
      .en       (bus.ch_en[i]),
      .sel      (bus.rate_sel[i*SEL_W +: SEL_W]),
      .cnt      (cnt_q),
      .clr      (clr_c),
`ifdef FREQDIV_SCHED_TICKCNT_EN
      .tick_cnt (tick_cnt_w[i*TC_W +: TC_W]),
`endif
      .tick     (tick_w[i])
    );
  end

endmodule

// File: tb/tb_freqdiv_sched.sv
// Scoreboard bench for freqdiv_sched (CNT_W=6, N_CH=4); build with FREQDIV_SCHED_TICKCNT_EN to cover tick_cnt.
module tb_freqdiv_sched;

  localparam int unsigned CW = 6;
  localparam int unsigned NC = 4;
  localparam int unsigned SW = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_STEP  = 2'd3;

  localparam logic [3:0] C_START = 4'b1000;
  localparam logic [3:0] C_PAUSE = 4'b0100;
  localparam logic [3:0] C_STOP  = 4'b0010;
  localparam logic [3:0] C_STEP  = 4'b0001;

  typedef struct packed {
    logic [NC-1:0] tick;
    logic          clk_out;
    logic [1:0]    st;
    logic [31:0]   tc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  freqdiv_sched_if #(.N_CH(NC), .SEL_W(SW)) bus ();

  freqdiv_sched #(.CNT_W(CW), .N_CH(NC), .SEL_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  exp_t          sb_q[$];
  logic [1:0]    m_st;
  int unsigned   m_cnt;
  logic [NC-1:0] m_tick;
  int unsigned   m_tc[NC];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_st   = S_IDLE;
    m_cnt  = 0;
    m_tick = '0;
    for (int i = 0; i < NC; i++) m_tc[i] = 0;
  endtask

  // Predict post-edge outputs from the current inputs, clock once, compare.
  task automatic step_clk();
    exp_t          e;
    logic [1:0]    ns;
    int unsigned   ncnt;
    int unsigned   mask;
    int unsigned   sel;
    logic [NC-1:0] nt;
    ns = m_st;
    if (bus.cmd.stop) ns = S_IDLE;
    else begin
      case (m_st)
        S_IDLE:  if (bus.cmd.start) ns = S_RUN;
        S_RUN:   if (bus.cmd.pause) ns = S_PAUSE;
        S_PAUSE: if (bus.cmd.start) ns = S_RUN; else if (bus.cmd.step) ns = S_STEP;
        default: ns = S_PAUSE;
      endcase
    end
    if (ns == S_IDLE)      ncnt = 0;
    else if (m_st == S_RUN) ncnt = (m_cnt + 1) % (1 << CW);
    else                   ncnt = m_cnt;
    for (int i = 0; i < NC; i++) begin
      sel  = 32'(bus.rate_sel[i*SW +: SW]);
      mask = (1 << (CW - sel)) - 1;
      if (m_st == S_RUN)       nt[i] = bus.ch_en[i] && ((m_cnt & mask) == mask);
      else if (m_st == S_STEP) nt[i] = bus.ch_en[i];
      else                     nt[i] = 1'b0;
    end
    e.tc = '0;
    for (int i = 0; i < NC; i++) begin
      if (ns == S_IDLE || m_st == S_IDLE) m_tc[i] = 0;
      else if (m_tick[i] && m_tc[i] < 255) m_tc[i] = m_tc[i] + 1;
      e.tc[i*8 +: 8] = 8'(m_tc[i]);
    end
    e.tick    = nt;
    e.clk_out = (ns != S_IDLE) && (((ncnt >> (CW - 1)) & 1) == 1);
    e.st      = ns;
    m_st   = ns;
    m_cnt  = ncnt;
    m_tick = nt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    e = sb_q.pop_front();
    check_eq("tick", 32'(bus.tick), 32'(e.tick));
    check_eq("clk_out", 32'(bus.clk_out), 32'(e.clk_out));
    check_eq("state_o", 32'(bus.state_o), 32'(e.st));
`ifdef FREQDIV_SCHED_TICKCNT_EN
    check_eq("tick_cnt", bus.tick_cnt, e.tc);
`endif
  endtask

  task automatic pulse(input logic [3:0] c);
    bus.cmd = c;
    step_clk();
    bus.cmd = '0;
  endtask

  task automatic wait_tick(input int ch, input int budget, input int s, output int n);
    n = -1;
    for (int k = 0; k < budget; k++) begin
      step_clk();
      if (bus.tick[ch]) begin
        n = cyc - s;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    int n;
    int t1;
    int co;
    int cnt_ticks;
    rst          = 1'b1;
    bus.cmd      = '0;
    bus.ch_en    = '0;
    bus.rate_sel = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_state", 32'(bus.state_o), 32'(S_IDLE));
    check_eq("rst_tick", 32'(bus.tick), 0);
    check_eq("rst_clk_out", 32'(bus.clk_out), 0);
    rst = 1'b0;

    // IDLE ignores pause and step
    pulse(C_PAUSE);
    pulse(C_STEP);
    check_eq("idle_ignore", 32'(bus.state_o), 32'(S_IDLE));

    // ch0 rate 3, ch1 rate 0
    bus.ch_en    = 4'b0011;
    bus.rate_sel = 8'b0000_0011;
    pulse(C_START);
    s = cyc;
    wait_tick(0, 20, s, n);
    check_eq("first_tick_r3", 32'(n), 8);
    wait_tick(0, 20, s, n);
    check_eq("second_tick_r3", 32'(n), 16);
    t1 = -1;
    co = -1;
    for (int k = 0; k < 60; k++) begin
      step_clk();
      if (bus.tick[1] && t1 < 0) t1 = cyc - s;
      if (bus.clk_out && co < 0) co = cyc - s;
    end
    check_eq("first_tick_r0", 32'(t1), 64);
    check_eq("clk_out_rise", 32'(co), 32);

    // pause after 20 RUN cycles, hold, then single step
    pulse(C_STOP);
    check_eq("stop_idle", 32'(bus.state_o), 32'(S_IDLE));
    pulse(C_START);
    repeat (19) step_clk();
    pulse(C_PAUSE);
    check_eq("pause_state", 32'(bus.state_o), 32'(S_PAUSE));
    cnt_ticks = 0;
    repeat (50) begin
      step_clk();
      if (bus.tick != '0) cnt_ticks++;
    end
    check_eq("pause_no_ticks", 32'(cnt_ticks), 0);
    pulse(C_STEP);
    check_eq("step_state", 32'(bus.state_o), 32'(S_STEP));
    step_clk();
    check_eq("step_tick", 32'(bus.tick), 32'(4'b0011));
    check_eq("step_back", 32'(bus.state_o), 32'(S_PAUSE));

    // resume in phase from cnt=20: next rate-3 match at 23
    pulse(C_START);
    s = cyc;
    wait_tick(0, 20, s, n);
    check_eq("resume_tick", 32'(n), 4);

    // stop mid-run then restart from zero
    pulse(C_STOP);
    check_eq("stop_mid", 32'(bus.state_o), 32'(S_IDLE));
    pulse(C_START);
    s = cyc;
    wait_tick(0, 20, s, n);
    check_eq("restart_tick", 32'(n), 8);

    // start+stop together from IDLE
    pulse(C_STOP);
    pulse(C_START | C_STOP);
    check_eq("start_stop", 32'(bus.state_o), 32'(S_IDLE));

    // pause+step together in RUN
    pulse(C_START);
    repeat (3) step_clk();
    pulse(C_PAUSE | C_STEP);
    check_eq("pause_step_st", 32'(bus.state_o), 32'(S_PAUSE));
    step_clk();
    check_eq("pause_step_st2", 32'(bus.state_o), 32'(S_PAUSE));
    check_eq("pause_step_tick", 32'(bus.tick), 0);

    // live rate change 0 -> 3 at cnt=40: next tick at cnt=47
    pulse(C_STOP);
    bus.ch_en    = 4'b0001;
    bus.rate_sel = 8'b0000_0000;
    pulse(C_START);
    s = cyc;
    repeat (40) step_clk();
    bus.rate_sel = 8'b0000_0011;
    wait_tick(0, 20, s, n);
    check_eq("rate_change", 32'(n), 48);

    // asynchronous reset mid-RUN
    #3;
    check_eq("pre_rst_run", 32'(bus.state_o), 32'(S_RUN));
    rst = 1'b1;
    #1;
    check_eq("async_rst_state", 32'(bus.state_o), 32'(S_IDLE));
    check_eq("async_rst_tick", 32'(bus.tick), 0);
    check_eq("async_rst_clk_out", 32'(bus.clk_out), 0);
    model_reset();
    #1;
    rst = 1'b0;
    step_clk();

`ifdef FREQDIV_SCHED_TICKCNT_EN
    bus.ch_en    = 4'b0001;
    bus.rate_sel = 8'b0000_0011;
    pulse(C_START);
    repeat (2100) step_clk();
    check_eq("tick_cnt_sat", 32'(bus.tick_cnt[7:0]), 255);
    pulse(C_STOP);
    step_clk();
    check_eq("tick_cnt_clr", bus.tick_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
